// File: rtl/zap_cp15_responder_if.sv
// CPU <-> CP15 coprocessor handshake plus the CPU register-file access port.
// Signal prefixes are from the coprocessor's point of view.
interface zap_cp15_responder_if #(
    parameter int unsigned IDX_W = 6
);
    logic             i_dav;
    logic [31:0]      i_cp_word;
    logic             o_done;
    logic             o_reg_en;
    logic [IDX_W-1:0] o_reg_rd_index;
    logic [31:0]      i_reg_rd_data;
    logic             o_reg_wr;
    logic [IDX_W-1:0] o_reg_wr_index;
    logic [31:0]      o_reg_wr_data;

    modport master (
        output i_dav, i_cp_word, i_reg_rd_data,
        input  o_done, o_reg_en, o_reg_rd_index, o_reg_wr, o_reg_wr_index, o_reg_wr_data
    );

    modport slave (
        input  i_dav, i_cp_word, i_reg_rd_data,
        output o_done, o_reg_en, o_reg_rd_index, o_reg_wr, o_reg_wr_index, o_reg_wr_data
    );
endinterface

// File: rtl/zap_cp15_responder.sv
// CP15 responder: 16-entry control register bank serving MCR/MRC over the
// coprocessor handshake; all other forwarded words are simply acknowledged.
module zap_cp15_responder #(
    parameter int unsigned PHY_REGS   = 46,
    parameter logic [31:0] CPU_ID     = 32'h4107_0000,
    parameter logic [31:0] CTRL_RESET = 32'h0000_0000
) (
    input  logic                  i_clk,
    input  logic                  i_reset_n,
    zap_cp15_responder_if.slave   cp,
    output logic [31:0]           o_ctrl
);

    localparam int unsigned IDX_W = $clog2(PHY_REGS);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_CAP,
        S_WR,
        S_DONE
    } state_t;

    state_t           r_state;
    logic             r_done;
    logic             r_reg_en;
    logic             r_reg_wr;
    logic [IDX_W-1:0] r_rd_index;
    logic [IDX_W-1:0] r_wr_index;
    logic [31:0]      r_wr_data;
    logic [3:0]       r_crn;
    logic [31:0]      r_bank [16];

    // Decode of the incoming word; only used on the IDLE edge that latches it
    logic       w_is_cp15;
    logic       w_l;
    logic [3:0] w_crn;
    logic [3:0] w_rd;
    logic [31:0] w_cp_rdata;
    logic       w_unused_bits;

    assign w_l       = cp.i_cp_word[20];
    assign w_crn     = cp.i_cp_word[19:16];
    assign w_rd      = cp.i_cp_word[15:12];
    assign w_is_cp15 = (cp.i_cp_word[27:24] == 4'b1110) && cp.i_cp_word[4]
                    && (cp.i_cp_word[11:8] == 4'hF);
    assign w_cp_rdata = (w_crn == 4'd0) ? CPU_ID : r_bank[w_crn];

    // Condition, opc1, opc2 and CRm carry no meaning here
    assign w_unused_bits = ^{cp.i_cp_word[31:28], cp.i_cp_word[23:21],
                             cp.i_cp_word[7:5], cp.i_cp_word[3:0]};

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state    <= S_IDLE;
            r_done     <= 1'b0;
            r_reg_en   <= 1'b0;
            r_reg_wr   <= 1'b0;
            r_rd_index <= '0;
            r_wr_index <= '0;
            r_wr_data  <= '0;
            r_crn      <= '0;
            for (int i = 0; i < 16; i++) begin
                r_bank[i] <= 32'h0;
            end
            r_bank[1]  <= CTRL_RESET;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (cp.i_dav) begin
                        r_crn <= w_crn;
                        if (!w_is_cp15) begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                        end else if (!w_l) begin
                            r_state    <= S_RD;
                            r_reg_en   <= 1'b1;
                            r_reg_wr   <= 1'b0;
                            r_rd_index <= IDX_W'(w_rd);
                        end else begin
                            // PC as MRC destination is suppressed: no CPU write
                            r_state    <= S_WR;
                            r_reg_en   <= (w_rd != 4'hF);
                            r_reg_wr   <= (w_rd != 4'hF);
                            r_wr_index <= IDX_W'(w_rd);
                            r_wr_data  <= w_cp_rdata;
                        end
                    end
                end
                S_RD: begin
                    r_reg_en <= 1'b0;
                    r_state  <= cp.i_dav ? S_CAP : S_IDLE;
                end
                S_CAP: begin
                    if (!cp.i_dav) begin
                        r_state <= S_IDLE;
                    end else begin
                        if (r_crn != 4'd0) begin
                            r_bank[r_crn] <= cp.i_reg_rd_data;
                        end
                        r_state <= S_DONE;
                        r_done  <= 1'b1;
                    end
                end
                S_WR: begin
                    r_reg_en <= 1'b0;
                    r_reg_wr <= 1'b0;
                    if (!cp.i_dav) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_state <= S_DONE;
                        r_done  <= 1'b1;
                    end
                end
                S_DONE: begin
                    if (!cp.i_dav) begin
                        r_state <= S_IDLE;
                        r_done  <= 1'b0;
                    end
                end
                default: begin
                    r_state  <= S_IDLE;
                    r_done   <= 1'b0;
                    r_reg_en <= 1'b0;
                    r_reg_wr <= 1'b0;
                end
            endcase
        end
    end

    // Strobes are gated with i_dav so a flush cannot leak an access to the CPU
    assign cp.o_reg_en       = r_reg_en & cp.i_dav;
    assign cp.o_reg_wr       = r_reg_wr & cp.i_dav;
    assign cp.o_done         = r_done;
    assign cp.o_reg_rd_index = r_rd_index;
    assign cp.o_reg_wr_index = r_wr_index;
    assign cp.o_reg_wr_data  = r_wr_data;
    assign o_ctrl            = r_bank[1];

endmodule

// File: doc/zap_cp15_responder.md
Name: zap_cp15_responder

Overview:
- Coprocessor-side end of the CPU coprocessor handshake: the CPU drives a valid qualifier plus a 32-bit instruction word, and waits for done.
- Holds a 16-entry CP15 control register bank and executes MCR (CPU reg -> CP reg) and MRC (CP reg -> CPU reg) using a CPU register-file access port.
- Acknowledges all other forwarded words (CDP, LDC, STC) with no effect.
- Sits beside the core; the control register (c1) is exported for system use.

Parameters:
- PHY_REGS, 46: number of physical CPU registers; the index ports are $clog2(PHY_REGS) bits wide (6 at default).
- CPU_ID, 32'h4107_0000: read-only value of c0.
- CTRL_RESET, 32'h0000_0000: reset value of c1.

Ports:
- i_clk  in  1  clock; all state changes on rising edge.
- i_reset_n  in  1  asynchronous active-low reset.
- i_dav  in  1  coprocessor request valid, held high by the CPU until it sees done.
- i_cp_word  in  32  coprocessor instruction word; stable while i_dav is high.
- o_done  out  1  request complete.
- o_reg_en  out  1  CPU register-file access strobe.
- o_reg_rd_index  out  $clog2(PHY_REGS)  CPU register read index.
- i_reg_rd_data  in  32  read data; valid the cycle after a read strobe.
- o_reg_wr  out  1  write qualifier (meaningful when o_reg_en is high).
- o_reg_wr_index  out  $clog2(PHY_REGS)  CPU register write index.
- o_reg_wr_data  out  32  write data.
- o_ctrl  out  32  current value of c1.

Behaviour:
- Reset (i_reset_n low, asynchronous):
  - state = IDLE; o_done = 0; o_reg_en = 0; o_reg_wr = 0.
  - Both index outputs = 0; o_reg_wr_data = 0.
  - c1 = CTRL_RESET; c2..c15 = 0; o_ctrl = CTRL_RESET.
  - Reset mid-operation abandons the request with no commit.
- Decode fields of the latched word W (latched on the IDLE->busy transition):
  - L = W[20]; CRn = W[19:16]; Rd = W[15:12]; cp# = W[11:8].
  - MCR/MRC: W[27:24] = 4'b1110, W[4] = 1, cp# = 4'hF.
  - Anything else is "unsupported".
- Index mapping: CPU register index = zero-extended Rd. Bank translation is done upstream.
- States: IDLE, RD, CAP, WR, DONE.
  - IDLE, i_dav = 1, latch W, then:
    - MCR -> RD.
    - MRC -> WR.
    - unsupported -> DONE.
  - RD: o_reg_en = 1, o_reg_wr = 0, o_reg_rd_index = Rd. Next state CAP.
  - CAP: write i_reg_rd_data into c[CRn], then -> DONE.
    - CRn = 0 is a no-op (c0 is read-only).
  - WR: o_reg_en = 1, o_reg_wr = 1, o_reg_wr_index = Rd, o_reg_wr_data = c[CRn] (c0 returns CPU_ID). Next state DONE.
    - Rd = 15: no CPU write issued (o_reg_en = 0), still -> DONE.
  - DONE: o_done = 1. Stays in DONE until i_dav is sampled 0, then -> IDLE.
- o_done is a pure decode of state == DONE, so it never rises in the same cycle as i_dav.
- Latency, counted from the edge that samples i_dav high in IDLE:
  - MCR: o_done high 3 cycles later.
  - MRC: o_done high 2 cycles later.
  - unsupported: o_done high 1 cycle later.
- Flush (i_dav low in RD, CAP or WR):
  - Go to IDLE; no register commit.
  - o_reg_en and o_reg_wr are combinationally gated with i_dav, so no strobe reaches the CPU in that cycle.
- Back-to-back requests: a new request is accepted only from IDLE. After DONE, i_dav must be low for at least one sampled cycle before the next word is accepted.
- opc1, opc2 and CRm are ignored. W[31:28] (condition) is ignored; the CPU resolves conditions before issuing.
- o_ctrl = c1, registered; it updates the cycle after CAP.

Test Plan:
- MCR p15,0,r3,c1,c0,0 (i_dav = 1, i_cp_word = 32'hEE013F10, i_reg_rd_data = 32'h0000_1005 one cycle after the RD strobe):
  - RD strobe with o_reg_rd_index = 3.
  - o_ctrl = 32'h0000_1005.
  - o_done high 3 cycles after acceptance.
- MRC p15,0,r5,c1,c0,0 after the MCR test (32'hEE115F10):
  - One cycle with o_reg_en = 1, o_reg_wr = 1, o_reg_wr_index = 5, o_reg_wr_data = 32'h0000_1005.
  - o_done 2 cycles after acceptance.
- MRC r2,c0 (32'hEE102F10): write data = CPU_ID = 32'h4107_0000. A preceding MCR to c0 leaves it unchanged.
- Unsupported word LDC (32'hED930F00): no o_reg_en pulse; o_done high 1 cycle after acceptance.
- Flush: issue MCR, drop i_dav during CAP:
  - c1 is unchanged.
  - state returns to IDLE.
  - o_done never rises.
  - No write strobe is observed.
- Hold and reset:
  - Keep i_dav high 5 cycles in DONE: o_done stays 1, no new request is accepted.
  - Pulse i_reset_n low mid-WR: all outputs go to 0 immediately and o_ctrl = CTRL_RESET.
